// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU / PC+4 / load results and an optional mul/div
// result port into one registered register-file write port. Build option: WB_MULDIV_PORT_EN.
module writeback_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [4:0]      wb_rd,
    input  logic [1:0]      wb_sel,
    input  logic [XLEN-1:0] wb_alu,
    input  logic [XLEN-1:0] wb_pc4,
    input  logic [2:0]      wb_funct3,
    input  logic [1:0]      wb_offset,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            md_valid,
    input  logic [4:0]      md_rd,
    input  logic [XLEN-1:0] md_data,
    output logic            md_ready,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            reg_write,
    output logic            load_pending
);

    // state     | meaning
    // IDLE      | accepting MEM/WB instructions
    // LOAD_WAIT | load accepted, waiting for the memory response
    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    state_e            state_q, state_d;
    logic [4:0]        ld_rd_q, ld_rd_d;
    logic [2:0]        ld_funct3_q, ld_funct3_d;
    logic [1:0]        ld_offset_q, ld_offset_d;
    logic              reg_write_q, reg_write_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;

    logic              in_idle;
    logic              wb_accept;
    logic              wb_direct;
    logic              load_done;
    logic              md_ready_c;
    logic              md_write;

    function automatic logic [XLEN-1:0] load_align(
        input logic [2:0]      funct3,
        input logic [1:0]      offset,
        input logic [XLEN-1:0] data
    );
        logic [7:0]  lbyte;
        logic [15:0] lhalf;
        logic [XLEN-1:0] res;
        lbyte = data[{offset, 3'b000} +: 8];
        lhalf = data[{offset[1], 4'b0000} +: 16];
        case (funct3)
            3'b000:  res = {{(XLEN-8){lbyte[7]}}, lbyte};
            3'b100:  res = {{(XLEN-8){1'b0}}, lbyte};
            3'b001:  res = {{(XLEN-16){lhalf[15]}}, lhalf};
            3'b101:  res = {{(XLEN-16){1'b0}}, lhalf};
            default: res = data;
        endcase
        return res;
    endfunction

    always_comb begin
        in_idle   = (state_q == IDLE);
        wb_accept = in_idle && wb_valid;
        wb_direct = wb_accept && ((wb_sel == SEL_ALU) || (wb_sel == SEL_PC4))
                    && (wb_rd != 5'd0);
        load_done = !in_idle && mem_rvalid;
    end

`ifdef WB_MULDIV_PORT_EN
    // The pipeline always owns the write port when it has something scheduled.
    assign md_ready_c = !wb_direct && !load_done;
    assign md_write   = md_valid && md_ready_c && (md_rd != 5'd0);
`else
    logic unused_md;
    assign unused_md  = ^{md_valid, md_rd, md_data};
    assign md_ready_c = 1'b0;
    assign md_write   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ld_rd_d     = ld_rd_q;
        ld_funct3_d = ld_funct3_q;
        ld_offset_d = ld_offset_q;
        reg_write_d = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;

        if (load_done) begin
            state_d = IDLE;
            if (ld_rd_q != 5'd0) begin
                reg_write_d = 1'b1;
                rd_addr_d   = ld_rd_q;
                rd_data_d   = load_align(ld_funct3_q, ld_offset_q, mem_rdata);
            end
        end else if (wb_direct) begin
            reg_write_d = 1'b1;
            rd_addr_d   = wb_rd;
            rd_data_d   = (wb_sel == SEL_PC4) ? wb_pc4 : wb_alu;
        end else if (md_write) begin
            reg_write_d = 1'b1;
            rd_addr_d   = md_rd;
            rd_data_d   = md_data;
        end

        if (wb_accept && (wb_sel == SEL_LOAD)) begin
            state_d     = LOAD_WAIT;
            ld_rd_d     = wb_rd;
            ld_funct3_d = wb_funct3;
            ld_offset_d = wb_offset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ld_rd_q     <= 5'd0;
            ld_funct3_q <= 3'd0;
            ld_offset_q <= 2'd0;
            reg_write_q <= 1'b0;
            rd_addr_q   <= 5'd0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ld_rd_q     <= ld_rd_d;
            ld_funct3_q <= ld_funct3_d;
            ld_offset_q <= ld_offset_d;
            reg_write_q <= reg_write_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign wb_ready     = (state_q == IDLE);
    assign load_pending = (state_q == LOAD_WAIT);
    assign md_ready     = md_ready_c;
    assign reg_write    = reg_write_q;
    assign rd_addr      = rd_addr_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit; expected writes are queued as stimulus is
// driven and compared after the following clock edge.
module tb_writeback_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [1:0]      wb_sel;
    logic [XLEN-1:0] wb_alu;
    logic [XLEN-1:0] wb_pc4;
    logic [2:0]      wb_funct3;
    logic [1:0]      wb_offset;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            md_valid;
    logic [4:0]      md_rd;
    logic [XLEN-1:0] md_data;
    logic            md_ready;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            reg_write;
    logic            load_pending;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic            we;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
        string           tag;
    } exp_t;
    exp_t sb[$];

    writeback_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_sel(wb_sel),
        .wb_alu(wb_alu), .wb_pc4(wb_pc4), .wb_funct3(wb_funct3), .wb_offset(wb_offset),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .reg_write(reg_write),
        .load_pending(load_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue the expectation for the coming edge, clock, then pop and compare.
    task automatic cyc(input string tag, input logic we, input logic [4:0] addr,
                       input logic [XLEN-1:0] data);
        exp_t e;
        e.we = we; e.addr = addr; e.data = data; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".we"}, {31'd0, reg_write}, {31'd0, e.we});
        if (e.we) begin
            chk({e.tag, ".addr"}, {27'd0, rd_addr}, {27'd0, e.addr});
            chk({e.tag, ".data"}, rd_data, e.data);
        end
    endtask

    task automatic idle_inputs();
        wb_valid = 0; wb_rd = 0; wb_sel = 2'b11; wb_alu = 0; wb_pc4 = 0;
        wb_funct3 = 0; wb_offset = 0; mem_rvalid = 0; mem_rdata = 0;
        md_valid = 0; md_rd = 0; md_data = 0;
    endtask

    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] off, input logic [XLEN-1:0] rdata,
                           input logic exp_we, input logic [XLEN-1:0] exp_data);
        wb_valid = 1; wb_sel = 2'b01; wb_rd = rd; wb_funct3 = f3; wb_offset = off;
        cyc({tag, ".acc"}, 0, 0, 0);
        wb_valid = 0;
        chk({tag, ".ready_wait"}, {31'd0, wb_ready}, 0);
        chk({tag, ".pending"}, {31'd0, load_pending}, 1);
        cyc({tag, ".wait"}, 0, 0, 0);
        mem_rvalid = 1; mem_rdata = rdata;
        cyc(tag, exp_we, rd, exp_data);
        mem_rvalid = 0;
        chk({tag, ".ready_after"}, {31'd0, wb_ready}, 1);
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        cyc("reset0", 0, 0, 0);
        cyc("reset1", 0, 0, 0);
        chk("rst.rd_addr", {27'd0, rd_addr}, 0);
        chk("rst.rd_data", rd_data, 0);
        chk("rst.ready", {31'd0, wb_ready}, 1);
        chk("rst.pending", {31'd0, load_pending}, 0);
        reset = 0;
        cyc("idle", 0, 0, 0);

        // ALU, PC+4, no-write select, x0 destination
        wb_valid = 1; wb_sel = 2'b00; wb_rd = 5; wb_alu = 32'h1234_5678; wb_pc4 = 32'hDEAD_0004;
        cyc("alu", 1, 5, 32'h1234_5678);
        wb_valid = 0;
        cyc("alu.pulse", 0, 0, 0);
        wb_valid = 1; wb_sel = 2'b10; wb_rd = 1; wb_pc4 = 32'h0000_0100;
        cyc("pc4", 1, 1, 32'h0000_0100);
        wb_sel = 2'b11; wb_rd = 9;
        cyc("sel11", 0, 0, 0);
        wb_sel = 2'b00; wb_rd = 0;
        cyc("x0_alu", 0, 0, 0);
        wb_valid = 0;

        // mem_rvalid in IDLE must be ignored
        mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
        cyc("rvalid_idle", 0, 0, 0);
        mem_rvalid = 0;

        do_load("lb_off2",  7, 3'b000, 2'd2, 32'h0080_0000, 1, 32'hFFFF_FF80);
        do_load("lhu_off2", 6, 3'b101, 2'd2, 32'hBEEF_1234, 1, 32'h0000_BEEF);
        do_load("lh_off2",  6, 3'b001, 2'd2, 32'hBEEF_1234, 1, 32'hFFFF_BEEF);
        do_load("lbu_off3", 2, 3'b100, 2'd3, 32'h80FF_7F01, 1, 32'h0000_0080);
        do_load("lb_off1",  3, 3'b000, 2'd1, 32'h80FF_7F01, 1, 32'h0000_007F);
        do_load("lb_off0",  3, 3'b000, 2'd0, 32'h80FF_7FF1, 1, 32'hFFFF_FFF1);
        do_load("lh_off0",  4, 3'b001, 2'd0, 32'h80FF_7F01, 1, 32'h0000_7F01);
        do_load("lh_off3",  4, 3'b001, 2'd3, 32'h1234_ABCD, 1, 32'h0000_1234);
        do_load("lhu_off1", 4, 3'b101, 2'd1, 32'h1234_ABCD, 1, 32'h0000_ABCD);
        do_load("lw",       9, 3'b010, 2'd0, 32'h80FF_7F01, 1, 32'h80FF_7F01);
        do_load("f3_011",  10, 3'b011, 2'd1, 32'hA5A5_5A5A, 1, 32'hA5A5_5A5A);
        do_load("f3_110",  11, 3'b110, 2'd2, 32'h0123_4567, 1, 32'h0123_4567);
        do_load("f3_111",  12, 3'b111, 2'd3, 32'h89AB_CDEF, 1, 32'h89AB_CDEF);
        do_load("ld_x0",    0, 3'b010, 2'd0, 32'h5555_5555, 0, 0);

        // Instruction held valid during LOAD_WAIT is only accepted once back in IDLE
        wb_valid = 1; wb_sel = 2'b01; wb_rd = 13; wb_funct3 = 3'b010; wb_offset = 0;
        cyc("hold.acc", 0, 0, 0);
        wb_sel = 2'b00; wb_rd = 14; wb_alu = 32'h0000_0E0E;
        mem_rvalid = 1; mem_rdata = 32'h1313_1313;
        cyc("hold.ld", 1, 13, 32'h1313_1313);
        mem_rvalid = 0;
        cyc("hold.alu", 1, 14, 32'h0000_0E0E);
        wb_valid = 0;

        // Reset in LOAD_WAIT, with a simultaneous response, then a stray response
        wb_valid = 1; wb_sel = 2'b01; wb_rd = 8; wb_funct3 = 3'b010;
        cyc("rstld.acc", 0, 0, 0);
        wb_valid = 0;
        cyc("rstld.wait", 0, 0, 0);
        reset = 1; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        cyc("rstld.rst", 0, 0, 0);
        chk("rstld.rd_addr", {27'd0, rd_addr}, 0);
        chk("rstld.rd_data", rd_data, 0);
        reset = 0;
        cyc("rstld.stray", 0, 0, 0);
        mem_rvalid = 0;
        chk("rstld.ready", {31'd0, wb_ready}, 1);
        chk("rstld.pending", {31'd0, load_pending}, 0);

        // Reset beats a simultaneous accept
        reset = 1; wb_valid = 1; wb_sel = 2'b00; wb_rd = 15; wb_alu = 32'h1;
        cyc("rst_acc", 0, 0, 0);
        reset = 0; wb_valid = 0;
        cyc("rst_acc.after", 0, 0, 0);

`ifdef WB_MULDIV_PORT_EN
        md_valid = 1; md_rd = 3; md_data = 32'h0000_CAFE;
        wb_valid = 1; wb_sel = 2'b00; wb_rd = 4; wb_alu = 32'h0000_0044;
        chk("arb.md_ready_blk", {31'd0, md_ready}, 0);
        cyc("arb.pipe", 1, 4, 32'h0000_0044);
        wb_valid = 0;
        chk("arb.md_ready_free", {31'd0, md_ready}, 1);
        cyc("arb.md", 1, 3, 32'h0000_CAFE);
        md_valid = 0;
        cyc("arb.idle", 0, 0, 0);
        // Non-writing pipeline instructions leave the port to md
        md_valid = 1; md_rd = 20; md_data = 32'h2020_2020;
        wb_valid = 1; wb_sel = 2'b00; wb_rd = 0;
        chk("arb.x0_ready", {31'd0, md_ready}, 1);
        cyc("arb.x0_md", 1, 20, 32'h2020_2020);
        md_rd = 0;
        cyc("arb.md_x0", 0, 0, 0);
        wb_valid = 0; md_valid = 0;
        // Load response blocks md even when the load targets x0
        wb_valid = 1; wb_sel = 2'b01; wb_rd = 0; wb_funct3 = 3'b010;
        cyc("arb.ld_acc", 0, 0, 0);
        wb_valid = 0; md_valid = 1; md_rd = 21; md_data = 32'h2121_2121;
        chk("arb.wait_ready", {31'd0, md_ready}, 1);
        cyc("arb.wait_md", 1, 21, 32'h2121_2121);
        md_rd = 22; md_data = 32'h2222_2222; mem_rvalid = 1; mem_rdata = 32'h7;
        chk("arb.resp_blk", {31'd0, md_ready}, 0);
        cyc("arb.resp", 0, 0, 0);
        mem_rvalid = 0;
        cyc("arb.md_after", 1, 22, 32'h2222_2222);
        md_valid = 0;
`else
        md_valid = 1; md_rd = 3; md_data = 32'h0000_CAFE;
        chk("nomd.ready", {31'd0, md_ready}, 0);
        cyc("nomd.nowrite", 0, 0, 0);
        wb_valid = 1; wb_sel = 2'b00; wb_rd = 4; wb_alu = 32'h0000_0044;
        cyc("nomd.pipe", 1, 4, 32'h0000_0044);
        wb_valid = 0; md_valid = 0;
`endif
        cyc("end", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter: XLEN, default 32, data width of every data port.
REQ-002 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high; sampled on rising clk edge.
REQ-004 Port: wb_valid  in  1  MEM/WB instruction presented.
REQ-005 Port: wb_ready  out  1  instruction accepted when wb_valid && wb_ready.
REQ-006 Port: wb_rd  in  5  destination register index.
REQ-007 Port: wb_sel  in  2  source select:
- 00 ALU
- 01 LOAD
- 10 PC+4
- 11 no write
REQ-008 Port: wb_alu / wb_pc4  in  XLEN  ALU result / link address.
REQ-009 Port: wb_funct3  in  3  load type (LB, LH, LW, LBU, LHU); wb_offset  in  2  address bits [1:0].
REQ-010 Port: mem_rvalid  in  1, mem_rdata  in  XLEN  load response from data memory.
REQ-011 Port: md_valid  in  1, md_rd  in  5, md_data  in  XLEN, md_ready  out  1  multiply/divide result port.
REQ-012 Port: rd_addr  out  5, rd_data  out  XLEN, reg_write  out  1  registered write port to the register file.
REQ-013 Port: load_pending  out  1  high while a load awaits its response.

Function
REQ-014 rd_addr, rd_data and reg_write SHALL be registered; reg_write pulses exactly one cycle per write.
REQ-015 At most one register write SHALL occur per cycle; reg_write SHALL never be asserted with rd_addr = 0.
REQ-016 FSM states SHALL be IDLE and LOAD_WAIT; wb_ready = 1 in IDLE, 0 in LOAD_WAIT; load_pending = (state == LOAD_WAIT).
REQ-017 IDLE, accepted wb_sel 00/10 with wb_rd != 0: write wb_alu / wb_pc4 to wb_rd on the next cycle (latency 1).
REQ-018 IDLE, accepted wb_sel 11 or wb_rd = 0 (non-load): instruction consumed, no write.
REQ-019 IDLE, accepted wb_sel 01: capture rd, funct3, offset; move to LOAD_WAIT; mem_rvalid SHALL be ignored in IDLE.
REQ-020 LOAD_WAIT, mem_rvalid = 1: write the aligned, extended data to the captured rd on the next cycle; return to IDLE on that edge.
REQ-021 LOAD_WAIT completes even when captured rd = 0, without a write.
REQ-022 Load alignment rules:
- LB/LBU: byte = mem_rdata[8*offset +: 8], sign-/zero-extended.
- LH/LHU: half = mem_rdata[16*offset[1] +: 16], sign-/zero-extended; offset[0] ignored.
- LW and undefined funct3 (011, 110, 111): full word.
REQ-023 md_ready SHALL be 1 only when no pipeline write is scheduled for the same cycle, i.e. not (IDLE && wb_valid && wb_sel in {00,10} && wb_rd != 0) and not (LOAD_WAIT && mem_rvalid); the pipeline always wins.
REQ-024 md_valid && md_ready with md_rd != 0: write md_data to md_rd on the next cycle; md_rd = 0 is consumed without a write.
REQ-025 md_ready SHALL be combinational from current inputs and state; md_valid SHALL NOT gate wb_ready.

Reset
REQ-026 On reset:
- state = IDLE, reg_write = 0, rd_addr = 0, rd_data = 0, load_pending = 0, captured load fields cleared.
REQ-027 Reset during LOAD_WAIT discards the pending load; a later mem_rvalid SHALL produce no write.
REQ-028 Reset takes priority over every simultaneous accept or response in the same cycle.

Configuration
REQ-029 Macro WB_MULDIV_PORT_EN defined: md_* port and arbitration (REQ-023, REQ-024) compiled in.
REQ-030 Macro WB_MULDIV_PORT_EN undefined: md_valid, md_rd and md_data ignored, md_ready tied 0; all other behaviour unchanged.

Verification
REQ-031 ALU write: wb_valid=1, sel=00, rd=5, alu=0x12345678 -> next cycle reg_write=1, rd_addr=5, rd_data=0x12345678; following cycle reg_write=0.
REQ-032 LB sign extension: sel=01, rd=7, funct3=000, offset=2; then mem_rvalid=1, rdata=0x00800000 two cycles later -> wb_ready=0 and load_pending=1 while waiting; write rd=7, data=0xFFFFFF80 one cycle after rvalid.
REQ-033 LHU: funct3=101, offset=2, rdata=0xBEEF1234 -> data=0x0000BEEF; LH same input -> 0xFFFFBEEF.
REQ-034 Arbitration (macro on): md_valid=1, md_rd=3 in the same cycle as ALU write to rd=4 -> md_ready=0, rd=4 written; next cycle md_ready=1, rd=3 written; never two writes in one cycle.
REQ-035 x0 and reset: ALU write to rd=0 -> no reg_write; reset asserted in LOAD_WAIT, then mem_rvalid=1 -> no write, state IDLE, wb_ready=1.
